div_issue_ctrl: RTL and testbench

- Issue/control stage directly upstream of the iterative divider.
- Accepts M-extension divide/remainder requests from execute over a valid/ready handshake.
- Resolves RISC-V special cases (divide-by-zero, signed overflow) in one cycle without the divider. Otherwise holds operands stable, drives the divider enable until it reports finish, then captures and holds the result until writeback accepts it.
- Drives busy_o, which the pipeline uses for stall and hazard logic.

---
 rtl/div_issue_ctrl_if.sv | 27 ++
 rtl/div_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle between execute, writeback and the divide issue stage.
// Signal names carry the direction as seen from the issue stage (slave side).
interface div_issue_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_funct3_i;
    logic [XLEN-1:0]  req_a_i;
    logic [XLEN-1:0]  req_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic [XLEN-1:0]  resp_result_o;
    logic [TAG_W-1:0] resp_tag_o;

    modport master (
        output req_valid_i, req_funct3_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_result_o, resp_tag_o
    );

    modport slave (
        input  req_valid_i, req_funct3_i, req_a_i, req_b_i, req_tag_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_result_o, resp_tag_o
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issue/control stage in front of the iterative divider: resolves RISC-V special cases,
// sequences the divider and holds the result for writeback. Optional macro: DIV_RESULT_CACHE_EN.
module div_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    div_issue_ctrl_if.slave bus,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            div_en_o,
    output logic [2:0]      div_funct3_o,
    output logic [XLEN-1:0] div_a_o,
    output logic [XLEN-1:0] div_b_o,
    input  logic            div_finish_i,
    input  logic [XLEN-1:0] div_result_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q, state_d;
    logic             div_en_q, div_en_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             accept;
    logic             is_rem;
    logic             div_zero;
    logic             overflow;
    logic [XLEN-1:0]  special_result;
    logic             cache_hit;
    logic [XLEN-1:0]  cache_result;

    // funct3[0]=1 selects unsigned, funct3[1]=1 selects remainder
    assign is_rem   = bus.req_funct3_i[1];
    assign div_zero = (bus.req_b_i == '0);
    assign overflow = ~bus.req_funct3_i[0] && (bus.req_a_i == MIN_NEG) && (bus.req_b_i == '1);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = is_rem ? bus.req_a_i : '1;
        end else if (overflow) begin
            special_result = is_rem ? '0 : MIN_NEG;
        end
    end

    assign accept = bus.req_valid_i && (state_q == IDLE) && ~kill_i && bus.req_funct3_i[2];

`ifdef DIV_RESULT_CACHE_EN
    logic            cache_valid_q;
    logic [2:0]      cache_funct3_q;
    logic [XLEN-1:0] cache_a_q;
    logic [XLEN-1:0] cache_b_q;
    logic [XLEN-1:0] cache_result_q;
    logic            cache_wr;

    // Only completed results reach DONE, so a kill never leaves a bad entry behind
    assign cache_wr = (state_d == DONE) && (state_q != DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid_q  <= 1'b0;
            cache_funct3_q <= '0;
            cache_a_q      <= '0;
            cache_b_q      <= '0;
            cache_result_q <= '0;
        end else if (cache_wr) begin
            cache_valid_q  <= 1'b1;
            cache_funct3_q <= funct3_d;
            cache_a_q      <= a_d;
            cache_b_q      <= b_d;
            cache_result_q <= result_d;
        end
    end

    assign cache_hit    = cache_valid_q && (cache_funct3_q == bus.req_funct3_i)
                       && (cache_a_q == bus.req_a_i) && (cache_b_q == bus.req_b_i);
    assign cache_result = cache_result_q;
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        state_d  = state_q;
        div_en_d = div_en_q;
        funct3_d = funct3_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        tag_d    = tag_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = bus.req_funct3_i;
                    a_d      = bus.req_a_i;
                    b_d      = bus.req_b_i;
                    tag_d    = bus.req_tag_i;
                    if (div_zero || overflow) begin
                        result_d = special_result;
                        state_d  = DONE;
                    end else if (cache_hit) begin
                        result_d = cache_result;
                        state_d  = DONE;
                    end else begin
                        div_en_d = 1'b1;
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                if (kill_i) begin
                    div_en_d = 1'b0;
                    state_d  = IDLE;
                end else if (div_finish_i) begin
                    result_d = div_result_i;
                    div_en_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (kill_i || bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                div_en_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            div_en_q <= 1'b0;
            funct3_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_en_q <= div_en_d;
            funct3_q <= funct3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            tag_q    <= tag_d;
        end
    end

    assign bus.req_ready_o   = (state_q == IDLE);
    assign bus.resp_valid_o  = (state_q == DONE);
    assign bus.resp_result_o = result_q;
    assign bus.resp_tag_o    = tag_q;
    assign busy_o            = (state_q != IDLE);
    assign div_en_o          = div_en_q;
    assign div_funct3_o      = funct3_q;
    assign div_a_o           = a_q;
    assign div_b_o           = b_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a 67-cycle divider stand-in.
// Build with +define+DIV_RESULT_CACHE_EN to expect cached repeats at latency 1.
module tb_div_issue_ctrl;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;
    localparam int         FULL_LAT = 68;

    logic        clk;
    logic        rst;
    logic        kill;
    logic        busy;
    logic        div_en;
    logic [2:0]  div_funct3;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_finish;
    logic [31:0] div_result;
    logic        finishForce;
    int          divCnt;

    int assertCount = 0;
    int failCount   = 0;

    div_issue_ctrl_if #(.XLEN(32), .TAG_W(5)) bus ();

    div_issue_ctrl #(.XLEN(32), .TAG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .kill_i       (kill),
        .busy_o       (busy),
        .div_en_o     (div_en),
        .div_funct3_o (div_funct3),
        .div_a_o      (div_a),
        .div_b_o      (div_b),
        .div_finish_i (div_finish),
        .div_result_i (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: finishes in the 67th cycle that its enable is high
    function automatic logic [31:0] divModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
        case (f)
            F_DIV:   return $signed(a) / $signed(b);
            F_DIVU:  return a / b;
            F_REM:   return $signed(a) % $signed(b);
            F_REMU:  return a % b;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (div_en) divCnt <= divCnt + 1;
        else        divCnt <= 0;
    end

    assign div_finish = (div_en && divCnt == 66) || finishForce;
    assign div_result = divModel(div_funct3, div_a, div_b);

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", name, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] t);
        bus.req_valid_i  = valid;
        bus.req_funct3_i = f;
        bus.req_a_i      = a;
        bus.req_b_i      = b;
        bus.req_tag_i    = t;
    endtask

    // Called at a negedge in IDLE; returns at the negedge where resp_valid_o is first seen
    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                         output int lat, output int enCyc, output logic [31:0] res, output logic [4:0] rtag);
        applyStimulus(1'b1, f, a, b, t);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        lat   = 1;
        enCyc = 0;
        while (!bus.resp_valid_o && lat < 200) begin
            if (div_en) enCyc++;
            @(negedge clk);
            lat++;
        end
        res  = bus.resp_result_o;
        rtag = bus.resp_tag_o;
    endtask

    initial begin
        int          lat;
        int          enCyc;
        int          sawValid;
        logic [31:0] res;
        logic [4:0]  rtag;
        logic [31:0] cachedLat;

        rst         = 1'b1;
        kill        = 1'b0;
        finishForce = 1'b0;
        bus.resp_ready_i = 1'b1;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset state");
        checkOutput("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rst_div_en", 32'(div_en), 32'd0);
        checkOutput("rst_result", bus.resp_result_o, 32'd0);
        checkOutput("rst_tag", 32'(bus.resp_tag_o), 32'd0);
        checkOutput("rst_div_a", div_a, 32'd0);
        checkOutput("rst_div_b", div_b, 32'd0);
        checkOutput("rst_div_funct3", 32'(div_funct3), 32'd0);

        $display("[TB] DIVU 100/7 full latency");
        applyStimulus(1'b1, F_DIVU, 32'd100, 32'd7, 5'd5);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        checkOutput("divu_busy", 32'(busy), 32'd1);
        checkOutput("divu_req_ready", 32'(bus.req_ready_o), 32'd0);
        checkOutput("divu_div_a", div_a, 32'd100);
        checkOutput("divu_div_b", div_b, 32'd7);
        checkOutput("divu_div_funct3", 32'(div_funct3), 32'(F_DIVU));
        lat = 1;
        enCyc = 0;
        while (!bus.resp_valid_o && lat < 200) begin
            if (div_en) enCyc++;
            @(negedge clk);
            lat++;
        end
        checkOutput("divu_latency", 32'(lat), 32'(FULL_LAT));
        checkOutput("divu_en_cycles", 32'(enCyc), 32'd67);
        checkOutput("divu_result", bus.resp_result_o, 32'd14);
        checkOutput("divu_tag", 32'(bus.resp_tag_o), 32'd5);
        checkOutput("divu_en_dropped", 32'(div_en), 32'd0);
        @(negedge clk);
        checkOutput("divu_retired_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("divu_retired_ready", 32'(bus.req_ready_o), 32'd1);

        $display("[TB] signed REM/DIV of -7 by 2");
        runOp(F_REM, 32'hFFFF_FFF9, 32'd2, 5'd1, lat, enCyc, res, rtag);
        checkOutput("rem_neg_result", res, 32'hFFFF_FFFF);
        checkOutput("rem_neg_latency", 32'(lat), 32'(FULL_LAT));
        @(negedge clk);
        runOp(F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd2, lat, enCyc, res, rtag);
        checkOutput("div_neg_result", res, 32'hFFFF_FFFD);
        checkOutput("div_neg_tag", 32'(rtag), 32'd2);
        @(negedge clk);

        $display("[TB] divide by zero");
        runOp(F_DIV, 32'd5, 32'd0, 5'd7, lat, enCyc, res, rtag);
        checkOutput("div0_result", res, 32'hFFFF_FFFF);
        checkOutput("div0_latency", 32'(lat), 32'd1);
        checkOutput("div0_en_cycles", 32'(enCyc), 32'd0);
        checkOutput("div0_tag", 32'(rtag), 32'd7);
        @(negedge clk);
        runOp(F_REMU, 32'd5, 32'd0, 5'd8, lat, enCyc, res, rtag);
        checkOutput("remu0_result", res, 32'd5);
        checkOutput("remu0_latency", 32'(lat), 32'd1);
        @(negedge clk);

        $display("[TB] signed overflow");
        runOp(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, lat, enCyc, res, rtag);
        checkOutput("ovf_div_result", res, 32'h8000_0000);
        checkOutput("ovf_div_latency", 32'(lat), 32'd1);
        @(negedge clk);
        runOp(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, lat, enCyc, res, rtag);
        checkOutput("ovf_rem_result", res, 32'd0);
        checkOutput("ovf_rem_latency", 32'(lat), 32'd1);
        @(negedge clk);
        runOp(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, lat, enCyc, res, rtag);
        checkOutput("ovf_divu_result", res, 32'd0);
        checkOutput("ovf_divu_latency", 32'(lat), 32'(FULL_LAT));
        @(negedge clk);

        $display("[TB] rejected requests");
        applyStimulus(1'b1, 3'b000, 32'd8, 32'd2, 5'd3);
        @(negedge clk);
        checkOutput("nondiv_busy", 32'(busy), 32'd0);
        checkOutput("nondiv_req_ready", 32'(bus.req_ready_o), 32'd1);
        applyStimulus(1'b1, F_DIVU, 32'd8, 32'd2, 5'd3);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        checkOutput("idle_kill_busy", 32'(busy), 32'd0);
        finishForce = 1'b1;
        @(negedge clk);
        finishForce = 1'b0;
        checkOutput("stray_finish_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("stray_finish_busy", 32'(busy), 32'd0);

        $display("[TB] backpressure in DONE");
        bus.resp_ready_i = 1'b0;
        runOp(F_DIV, 32'd7, 32'd0, 5'd9, lat, enCyc, res, rtag);
        checkOutput("bp_latency", 32'(lat), 32'd1);
        applyStimulus(1'b1, F_DIVU, 32'd50, 32'd5, 5'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(bus.resp_valid_o), 32'd1);
            checkOutput("bp_result", bus.resp_result_o, 32'hFFFF_FFFF);
            checkOutput("bp_tag", 32'(bus.resp_tag_o), 32'd9);
            checkOutput("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
        end
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_busy", 32'(busy), 32'd0);
        checkOutput("bp_release_ready", 32'(bus.req_ready_o), 32'd1);
        runOp(F_DIVU, 32'd50, 32'd5, 5'd3, lat, enCyc, res, rtag);
        checkOutput("bp_next_result", res, 32'd10);
        checkOutput("bp_next_latency", 32'(lat), 32'(FULL_LAT));
        @(negedge clk);

        $display("[TB] kill in BUSY");
        applyStimulus(1'b1, F_DIVU, 32'd100, 32'd7, 5'd4);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        repeat (29) @(negedge clk);
        checkOutput("kill_pre_en", 32'(div_en), 32'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill_div_en", 32'(div_en), 32'd0);
        checkOutput("kill_busy", 32'(busy), 32'd0);
        sawValid = 0;
        repeat (80) begin
            if (bus.resp_valid_o) sawValid++;
            @(negedge clk);
        end
        checkOutput("kill_no_resp", 32'(sawValid), 32'd0);
        runOp(F_DIVU, 32'd9, 32'd3, 5'd6, lat, enCyc, res, rtag);
        checkOutput("post_kill_result", res, 32'd3);
        checkOutput("post_kill_latency", 32'(lat), 32'(FULL_LAT));
        checkOutput("post_kill_tag", 32'(rtag), 32'd6);
        @(negedge clk);

        $display("[TB] kill beats resp_ready in DONE");
        bus.resp_ready_i = 1'b0;
        runOp(F_DIV, 32'd3, 32'd0, 5'd13, lat, enCyc, res, rtag);
        checkOutput("done_kill_pre_valid", 32'(bus.resp_valid_o), 32'd1);
        kill = 1'b1;
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("done_kill_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("done_kill_busy", 32'(busy), 32'd0);

        $display("[TB] repeated DIVU 100/7");
        runOp(F_DIVU, 32'd100, 32'd7, 5'd14, lat, enCyc, res, rtag);
        checkOutput("repeat1_result", res, 32'd14);
        checkOutput("repeat1_latency", 32'(lat), 32'(FULL_LAT));
        @(negedge clk);
`ifdef DIV_RESULT_CACHE_EN
        cachedLat = 32'd1;
`else
        cachedLat = 32'(FULL_LAT);
`endif
        runOp(F_DIVU, 32'd100, 32'd7, 5'd15, lat, enCyc, res, rtag);
        checkOutput("repeat2_result", res, 32'd14);
        checkOutput("repeat2_tag", 32'(rtag), 32'd15);
        checkOutput("repeat2_latency", 32'(lat), cachedLat);
        @(negedge clk);

        $display("[TB] reset mid-BUSY");
        applyStimulus(1'b1, F_DIVU, 32'd1000, 32'd3, 5'd17);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        repeat (9) @(negedge clk);
        checkOutput("midrst_pre_en", 32'(div_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_div_en", 32'(div_en), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_div_a", div_a, 32'd0);
        checkOutput("midrst_div_b", div_b, 32'd0);
        checkOutput("midrst_tag", 32'(bus.resp_tag_o), 32'd0);
        checkOutput("midrst_result", bus.resp_result_o, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
